// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, default frame width and the
// mode decode that tells which SCLK edge carries sampled data.
package spi_pkg;

    localparam int SPI_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } spi_state_e;

    // Data is sampled on the rising SCLK edge in modes 0 and 3, and on the
    // falling edge in modes 1 and 2; the opposite edge is the shift edge.
    function automatic logic spi_sample_on_rise(input logic cpol, input logic cpha);
        return (cpol == cpha);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizer for one asynchronous pin plus a registered edge detector.
// The level and edge pulses come out of the same register stage, so a
// pulse and the level beside it describe the same moment on the pin.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              r_rise;
    logic              r_fall;
    logic              w_sync_out;

    assign w_sync_out = r_sync[STAGES-1];

    // Metastability chain followed by the edge-detect register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync[0] <= i_async;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_sync_out;
            r_rise <= w_sync_out & ~r_prev;
            r_fall <= ~w_sync_out & r_prev;
        end
    end

    assign o_level = r_prev;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/spi_slave_shifter.sv
// SPI peripheral-side shift engine. Pins are oversampled in the PCLK
// domain; frames are assembled into rx_data_o and a preloaded TX byte is
// serialized onto MISO honouring CPOL/CPHA and bit order.
module spi_slave_shifter
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              PCLK,
    input  logic              PRESET_n,
    input  logic              sclk_i,
    input  logic              ss_i,
    input  logic              mosi_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              lsbfe_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_load_i,
    input  logic              rx_read_i,
    output logic              miso_o,
    output logic              miso_oe_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              rx_full_o,
    output logic              tx_ready_o,
    output logic              overrun_o,
    output logic              busy_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    // Bit that goes out first for the current bit order
    function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    // Word with the outgoing bit removed
    function automatic logic [DATA_W-1:0] next_word(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    // Synchronized pin views
    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_ss_lvl,   w_ss_rise,   w_ss_fall;
    logic w_mosi_lvl, w_mosi_rise, w_mosi_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .i_clk   (PCLK),
        .i_rst_n (PRESET_n),
        .i_async (sclk_i),
        .o_level (w_sclk_lvl),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .i_clk   (PCLK),
        .i_rst_n (PRESET_n),
        .i_async (ss_i),
        .o_level (w_ss_lvl),
        .o_rise  (w_ss_rise),
        .o_fall  (w_ss_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .i_clk   (PCLK),
        .i_rst_n (PRESET_n),
        .i_async (mosi_i),
        .o_level (w_mosi_lvl),
        .o_rise  (w_mosi_rise),
        .o_fall  (w_mosi_fall)
    );

    // Only the SCLK edges and the MOSI level matter to the engine
    logic w_unused;
    assign w_unused = &{1'b0, w_sclk_lvl, w_mosi_rise, w_mosi_fall};

    // Engine state
    spi_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rx_sh;
    logic [DATA_W-1:0] r_tx_sh;
    logic [DATA_W-1:0] r_tx_hold;
    logic              r_tx_ready;
    logic              r_cpol, r_cpha, r_lsbfe;
    logic              r_miso;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_valid;
    logic              r_rx_full;
    logic              r_overrun;

    logic              w_samp_rise;
    logic              w_sample;
    logic              w_shift;
    logic              w_abort;
    logic              w_tx_accept;
    logic [DATA_W-1:0] w_tx_word;
    logic [DATA_W-1:0] w_rx_next;

    assign w_samp_rise = spi_sample_on_rise(r_cpol, r_cpha);
    assign w_sample    = w_samp_rise ? w_sclk_rise : w_sclk_fall;
    assign w_shift     = w_samp_rise ? w_sclk_fall : w_sclk_rise;
    assign w_abort     = w_ss_rise && (r_state != IDLE);
    assign w_tx_accept = tx_load_i && r_tx_ready;

    // A load landing in the LOAD cycle itself is used for this frame;
    // an empty holding register transmits all zeros.
    assign w_tx_word = w_tx_accept ? tx_data_i :
                       (r_tx_ready ? '0 : r_tx_hold);

    assign w_rx_next = r_lsbfe ? {w_mosi_lvl, r_rx_sh[DATA_W-1:1]}
                               : {r_rx_sh[DATA_W-2:0], w_mosi_lvl};

    // Frame FSM with RX/TX shift registers and the MISO output flop
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rx_sh <= '0;
            r_tx_sh <= '0;
            r_cpol  <= 1'b0;
            r_cpha  <= 1'b0;
            r_lsbfe <= 1'b0;
            r_miso  <= 1'b0;
        end else if (w_abort) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_ss_fall) r_state <= LOAD;
                end
                LOAD: begin
                    r_cpol  <= cpol_i;
                    r_cpha  <= cpha_i;
                    r_lsbfe <= lsbfe_i;
                    r_cnt   <= '0;
                    r_rx_sh <= '0;
                    // CPHA=0 puts the first bit out now; CPHA=1 waits for
                    // the first SCLK edge.
                    if (!cpha_i) begin
                        r_miso  <= first_bit(w_tx_word, lsbfe_i);
                        r_tx_sh <= next_word(w_tx_word, lsbfe_i);
                    end else begin
                        r_tx_sh <= w_tx_word;
                    end
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    if (w_sample) begin
                        r_rx_sh <= w_rx_next;
                        r_cnt   <= r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(DATA_W - 1)) r_state <= DONE;
                    end
                    // With CPHA=0 a shift edge before the first sample is the
                    // tail of the previous frame; the first bit is already out.
                    if (w_shift && (r_cpha || (r_cnt != '0))) begin
                        r_miso  <= first_bit(r_tx_sh, r_lsbfe);
                        r_tx_sh <= next_word(r_tx_sh, r_lsbfe);
                    end
                end
                DONE: begin
                    r_state <= w_ss_lvl ? IDLE : LOAD;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // TX holding register: filled by the register block, drained at LOAD
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            r_tx_hold  <= '0;
            r_tx_ready <= 1'b1;
        end else if (r_state == LOAD) begin
            r_tx_ready <= 1'b1;
        end else if (w_tx_accept) begin
            r_tx_hold  <= tx_data_i;
            r_tx_ready <= 1'b0;
        end
    end

    // RX status: publish frame at DONE; a coincident read loses to the new frame
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_full  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if ((r_state == DONE) && !w_abort) begin
                r_rx_data  <= r_rx_sh;
                r_rx_valid <= 1'b1;
                r_rx_full  <= 1'b1;
                if (r_rx_full && !rx_read_i) r_overrun <= 1'b1;
            end else if (rx_read_i) begin
                r_rx_full <= 1'b0;
            end
        end
    end

    assign miso_o     = r_miso;
    assign miso_oe_o  = ~w_ss_lvl;
    assign rx_data_o  = r_rx_data;
    assign rx_valid_o = r_rx_valid;
    assign rx_full_o  = r_rx_full;
    assign tx_ready_o = r_tx_ready;
    assign overrun_o  = r_overrun;
    assign busy_o     = (r_state != IDLE);

endmodule
